// File: rtl/interpolator_flow_pkg.sv
// Shared constants for the interpolator flow controller: FSM state codes,
// default sizing and the counter width helper.
package interpolator_flow_pkg;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int DEF_PIPELINE_LATENCY = 28;
  localparam int DEF_FIFO_DEPTH       = 32;

  // Bits needed to hold values 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/interpolator_flow_ctrl_sat_updown_counter.sv
// Saturating up/down counter. Simultaneous inc and dec cancel. A step that
// would pass 0 or MAX is suppressed and flagged on err_o for that cycle.
// cnt_d_o exposes the next value so callers can act on it in the same cycle.
module sat_updown_counter
  #(parameter int WIDTH = 6,
    parameter int MAX   = 32,
    parameter int INIT  = 0)
  (input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [WIDTH-1:0] cnt_o,
   output logic [WIDTH-1:0] cnt_d_o,
   output logic             err_o);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             err;

  // Next value with saturation at both ends.
  always_comb begin
    cnt_d = cnt_q;
    err   = 1'b0;
    if (inc_i && !dec_i) begin
      if (cnt_q == MAX_V) err = 1'b1;
      else                cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) err = 1'b1;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= INIT_V;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o   = cnt_q;
  assign cnt_d_o = cnt_d;
  assign err_o   = err;

endmodule

// File: rtl/interpolator_flow_ctrl.sv
// Credit-based flow controller in front of the non-stalling attribute
// interpolator. Beats are forwarded only while the downstream FIFO has a
// guaranteed slot; in-flight beats are tracked for pixelInPipeline and for
// draining. Optional statistics counters: define FLOW_CTRL_STATS_EN.
module interpolator_flow_ctrl
  import interpolator_flow_pkg::*;
  #(parameter int STREAM_WIDTH     = 160,
    parameter int PIPELINE_LATENCY = DEF_PIPELINE_LATENCY,
    parameter int FIFO_DEPTH       = DEF_FIFO_DEPTH)
  (input  logic                    clk,
   input  logic                    reset,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic                    s_axis_tlast,
   input  logic [STREAM_WIDTH-1:0] s_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast,
   output logic [STREAM_WIDTH-1:0] m_axis_tdata,
   input  logic                    pipe_out_valid,
   input  logic                    fifo_pop,
   input  logic                    drain_req,
   output logic                    drain_done,
   output logic                    pixelInPipeline,
   output logic                    err_flag
`ifdef FLOW_CTRL_STATS_EN
   ,
   output logic [31:0]             stat_pixels,
   output logic [31:0]             stat_stall_cycles,
   output logic [15:0]             stat_triangles
`endif
  );

  localparam int CNT_W   = cnt_w(FIFO_DEPTH);
  // The pipe physically holds at most min(latency, depth) beats, so this
  // ceiling only trips on a broken environment, never in normal use.
  localparam int INFL_LIM = PIPELINE_LATENCY + FIFO_DEPTH;
  localparam int INFL_MAX = (INFL_LIM > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : INFL_LIM;

  logic [1:0]       state_q, state_d;
  logic             drain_done_q, pip_q, err_q;
  logic [CNT_W-1:0] credits, credits_d, inflight, inflight_d;
  logic             cred_err, infl_err;
  logic             can_issue, issue;

  assign can_issue     = (state_q == ST_RUN) && (credits != '0);
  assign s_axis_tready = m_axis_tready & can_issue;
  assign m_axis_tvalid = s_axis_tvalid & can_issue;
  assign m_axis_tlast  = s_axis_tlast;
  assign m_axis_tdata  = s_axis_tdata;
  assign issue         = s_axis_tvalid & s_axis_tready;

  // Credits: consumed by an issue, returned by a FIFO pop.
  sat_updown_counter #(.WIDTH(CNT_W), .MAX(FIFO_DEPTH), .INIT(FIFO_DEPTH)) u_credits (
    .clk     (clk),
    .rst     (reset),
    .inc_i   (fifo_pop),
    .dec_i   (issue),
    .cnt_o   (credits),
    .cnt_d_o (credits_d),
    .err_o   (cred_err)
  );

  // In-flight beats: added on issue, removed when they leave the interpolator.
  sat_updown_counter #(.WIDTH(CNT_W), .MAX(INFL_MAX), .INIT(0)) u_inflight (
    .clk     (clk),
    .rst     (reset),
    .inc_i   (issue),
    .dec_i   (pipe_out_valid),
    .cnt_o   (inflight),
    .cnt_d_o (inflight_d),
    .err_o   (infl_err)
  );

  // Drain FSM: stop issuing, wait for the pipe to empty, hold DONE until released.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (drain_req)            state_d = ST_DRAIN;
      ST_DRAIN: if (inflight_d == '0)     state_d = ST_DONE;
      ST_DONE:  if (!drain_req)           state_d = ST_RUN;
      default:                            state_d = ST_RUN;
    endcase
  end

  // State and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      drain_done_q <= 1'b0;
      pip_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_done_q <= (state_d == ST_DONE);
      pip_q        <= (inflight_d != '0);
      err_q        <= err_q | cred_err | infl_err;
    end
  end

  assign drain_done      = drain_done_q;
  assign pixelInPipeline = pip_q;
  assign err_flag        = err_q;

`ifdef FLOW_CTRL_STATS_EN
  logic [31:0] pix_q, stall_q;
  logic [15:0] tri_q;

  // Free-running statistics, wrapping at full scale.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_q   <= '0;
      stall_q <= '0;
      tri_q   <= '0;
    end else begin
      if (issue)                          pix_q   <= pix_q + 32'd1;
      if (s_axis_tvalid && !s_axis_tready) stall_q <= stall_q + 32'd1;
      if (issue && s_axis_tlast)          tri_q   <= tri_q + 16'd1;
    end
  end

  assign stat_pixels       = pix_q;
  assign stat_stall_cycles = stall_q;
  assign stat_triangles    = tri_q;
`endif

endmodule

// File: tb/tb_interpolator_flow_ctrl.sv
// Randomized self-checking bench for interpolator_flow_ctrl with a
// transaction-level model of credits, in-flight beats and drain handshake.
module tb_interpolator_flow_ctrl;

  localparam int SW    = 160;
  localparam int LAT   = 28;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [SW-1:0] s_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [SW-1:0] m_axis_tdata;
  logic          pipe_out_valid, fifo_pop, drain_req;
  logic          drain_done, pixelInPipeline, err_flag;
`ifdef FLOW_CTRL_STATS_EN
  logic [31:0]   stat_pixels, stat_stall_cycles;
  logic [15:0]   stat_triangles;
`endif

  interpolator_flow_ctrl #(.STREAM_WIDTH(SW), .PIPELINE_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tdata    (s_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tdata    (m_axis_tdata),
    .pipe_out_valid  (pipe_out_valid),
    .fifo_pop        (fifo_pop),
    .drain_req       (drain_req),
    .drain_done      (drain_done),
    .pixelInPipeline (pixelInPipeline),
    .err_flag        (err_flag)
`ifdef FLOW_CTRL_STATS_EN
    ,
    .stat_pixels       (stat_pixels),
    .stat_stall_cycles (stat_stall_cycles),
    .stat_triangles    (stat_triangles)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: pending beats counted as plain integers.
  int m_cred, m_infl;
  bit m_blocked;      // drain requested, issuing stopped
  bit m_done;         // pipe empty while blocked, waiting for release
  bit m_err;
  int n_issue;
  int s_pix, s_stall, s_tri;

  // Environment: ideal fixed-latency pipe and FIFO occupancy.
  bit issue_hist[$];
  int occ;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tdata = '0;
    m_axis_tready = 1; pipe_out_valid = 0; fifo_pop = 0; drain_req = 0;
    @(posedge clk); #1;
    m_cred = DEPTH; m_infl = 0; m_blocked = 0; m_done = 0; m_err = 0;
    s_pix = 0; s_stall = 0; s_tri = 0;
    issue_hist.delete();
    for (int i = 0; i < LAT; i++) issue_hist.push_back(1'b0);
    occ = 0;
    chk("rst_pip", pixelInPipeline, 0);
    chk("rst_done", drain_done, 0);
    chk("rst_err", err_flag, 0);
    chk("rst_tready", s_axis_tready, 1);
    reset = 1'b0;
  endtask

  // One clock: drive at edge+1, check combinational outputs at negedge,
  // check registered outputs at next edge+1.
  task automatic cycle(input bit v, input bit last, input bit mrdy, input bit pop_en,
                       input bit dreq, input bit force_pov, input bit force_pop);
    bit exp_rdy, issue, pov, pop, ob;
    s_axis_tvalid = v;
    s_axis_tlast  = last;
    s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom, $urandom};
    m_axis_tready = mrdy;
    drain_req     = dreq;
    pov = issue_hist[0] | force_pov;
    pop = force_pop | (pop_en && occ > 0 && $urandom_range(0, 3) != 0);
    pipe_out_valid = pov;
    fifo_pop       = pop;
    @(negedge clk);
    exp_rdy = mrdy && !m_blocked && !m_done && (m_cred > 0);
    chk("tready", s_axis_tready, exp_rdy);
    chk("mvalid", m_axis_tvalid, v && !m_blocked && !m_done && (m_cred > 0));
    chk("tlast", m_axis_tlast, last);
    chk("tdata", m_axis_tdata == s_axis_tdata, 1);
    issue = v && exp_rdy;
    n_issue += issue;
    s_pix += issue;
    s_tri += (issue && last);
    s_stall += (v && !exp_rdy);
    // credits
    if (issue && !pop) m_cred--;
    else if (pop && !issue) begin
      if (m_cred == DEPTH) m_err = 1; else m_cred++;
    end
    // in-flight
    if (issue && !pov) m_infl++;
    else if (pov && !issue) begin
      if (m_infl == 0) m_err = 1; else m_infl--;
    end
    // drain handshake
    if (m_done) begin
      if (!dreq) m_done = 0;
    end else if (m_blocked) begin
      if (m_infl == 0) begin m_blocked = 0; m_done = 1; end
    end else if (dreq) m_blocked = 1;
    // environment
    ob = issue_hist.pop_front();
    issue_hist.push_back(issue);
    occ += ob;
    if (pop && occ > 0) occ--;
    @(posedge clk); #1;
    chk("pip", pixelInPipeline, m_infl != 0);
    chk("drain_done", drain_done, m_done);
    chk("err", err_flag, m_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base, pipc, iters;
    bit dr;
    do_reset();

    // Burst of 40 with no pops: exactly DEPTH issues.
    n_issue = 0;
    for (int i = 0; i < 40; i++) cycle(1, 0, 1, 0, 0, 0, 0);
    chk("s1_issues", n_issue, 32);
    chk("s1_tready", s_axis_tready, 0);

    // One pop returns one credit: exactly one more issue.
    cycle(1, 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, 0, 0, 0);
    chk("s2_issues", n_issue, 33);

    // Let everything leave and be popped.
    for (int i = 0; i < 150; i++) cycle(0, 0, 1, 1, 0, 0, 0);
    chk("s2_err", err_flag, 0);

    // Five consecutive beats: pipe busy for 5 + LAT - 1 cycles.
    pipc = 0;
    for (int i = 0; i < 5; i++) begin cycle(1, i == 4, 1, 1, 0, 0, 0); pipc += pixelInPipeline; end
    for (int i = 0; i < 40; i++) begin cycle(0, 0, 1, 1, 0, 0, 0); pipc += pixelInPipeline; end
    chk("s3_pip_cycles", pipc, 32);

    // Drain with 10 in flight; the 10th beat shares the cycle with drain_req.
    for (int i = 0; i < 9; i++) cycle(1, 0, 1, 1, 0, 0, 0);
    cycle(1, 0, 1, 1, 1, 0, 0);
    chk("s4_block", s_axis_tready, 0);
    iters = 0;
    while (!drain_done && iters < 100) begin cycle(1, 0, 1, 1, 1, 0, 0); iters++; end
    chk("s4_drain_lat", iters, 28);
    cycle(1, 0, 1, 1, 0, 0, 0);
    chk("s4_done_fall", drain_done, 0);
    chk("s4_tready_back", s_axis_tready, 1);
    for (int i = 0; i < 60; i++) cycle(0, 0, 1, 1, 0, 0, 0);

    // Random traffic with overlapping issue/pop/exit and random drains.
    dr = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) dr = ~dr;
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 7) == 0, $urandom_range(0, 9) != 0,
            1, dr, 0, 0);
    end
`ifdef FLOW_CTRL_STATS_EN
    chk("stat_pixels", stat_pixels, s_pix);
    chk("stat_stall", stat_stall_cycles, s_stall);
    chk("stat_tri", stat_triangles, s_tri);
`endif

    // Mid-stream reset, then exit with nothing in flight.
    for (int i = 0; i < 10; i++) cycle(1, 0, 1, 1, 0, 0, 0);
    do_reset();
    base = n_chk;
    cycle(0, 0, 1, 0, 0, 1, 0);
    chk("s6_unf_err", err_flag, 1);
    for (int i = 0; i < 5; i++) cycle(1, 0, 1, 1, 0, 0, 0);
    chk("s6_sticky", err_flag, 1);

    // Pop with credits full.
    do_reset();
    cycle(0, 0, 1, 0, 0, 0, 1);
    chk("s6_ovf_err", err_flag, 1);
    chk("s6_pip", pixelInPipeline, 0);
    for (int i = 0; i < 40; i++) cycle(1, 0, 1, 1, 0, 0, 0);
    chk("s6_ran", n_chk > base, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
